// File: rtl/sort_frame_controller_if.sv
// sort_frame_controller_if
//   Sample-in / result-out handshake bundle for sort_frame_controller.
//   slave  : the controller side (accepts samples, produces results)
//   master : the environment side (produces samples, accepts results)
// Signals
//   in_valid/in_ready/in_data/in_last        sample stream, transfer = valid & ready
//   out_valid/out_ready/out_data/out_index   result stream, largest magnitude first
//   out_pad/out_last                         padding flag, final beat of a frame
interface sort_frame_controller_if #(
  parameter int unsigned NETWORK_WIDTH = 16,
  parameter int unsigned INDEX_WIDTH   = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NETWORK_WIDTH-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [NETWORK_WIDTH-1:0] out_data;
  logic [INDEX_WIDTH-1:0]   out_index;
  logic                     out_pad;
  logic                     out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_index, out_pad, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_pad, out_last
  );
endinterface

// File: rtl/sort_frame_controller.sv
// sort_frame_controller
//   Collects a frame of up to SIZE unsigned magnitudes, tags each with its
//   arrival slot, sorts the frame once with a bitonic network and streams out
//   the TOP_K largest entries (with slot index and padding flag).
//   States: FILL -> SORT -> DRAIN -> FILL.
// Ports
//   clk       clock, all state on the rising edge
//   reset_n   asynchronous active-low reset
//   bus       sort_frame_controller_if.slave (sample in / result out handshakes)
//   overflow  one-cycle pulse when SIZE samples arrived without in_last
// Configuration
//   SORT_PIPE_STAGE_EN  when defined, a register sits between the buffer and
//                       the network; SORT takes two cycles (latency t+3).
//                       Undefined: single-cycle SORT, latency t+2.
module sort_frame_controller #(
  parameter int unsigned SIZE          = 16,
  parameter int unsigned TOP_K         = 4,
  parameter int unsigned NETWORK_WIDTH = 16,
  parameter int unsigned INDEX_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sort_frame_controller_if.slave   bus,
  output logic                     overflow
);
  localparam int unsigned CW = $clog2(SIZE);
  localparam int unsigned KW = NETWORK_WIDTH + INDEX_WIDTH;

  typedef enum logic [1:0] {ST_FILL, ST_LOAD, ST_SORT, ST_DRAIN} state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_wr_ptr;
  logic [CW-1:0]            r_rd_cnt;
  logic [NETWORK_WIDTH-1:0] r_buf [SIZE];
  logic [SIZE-1:0]          r_pad;
  logic [NETWORK_WIDTH-1:0] r_res_data [SIZE];
  logic [INDEX_WIDTH-1:0]   r_res_idx [SIZE];
  logic [SIZE-1:0]          r_res_pad;
  logic                     r_out_valid;
  logic [NETWORK_WIDTH-1:0] r_out_data;
  logic [INDEX_WIDTH-1:0]   r_out_index;
  logic                     r_out_pad;
  logic                     r_out_last;
  logic                     r_overflow;

  logic [KW-1:0]            w_buf_key [SIZE];
  logic [KW-1:0]            w_net_in  [SIZE];
  logic [KW-1:0]            w_net_out [SIZE];
  logic [KW-1:0]            w_swap;
  logic [NETWORK_WIDTH-1:0] w_sort_data [SIZE];
  logic [INDEX_WIDTH-1:0]   w_sort_idx  [SIZE];
  logic [SIZE-1:0]          w_sort_pad;
  logic                     w_in_xfer;
  logic                     w_out_xfer;
  logic [CW-1:0]            w_next_sel;

  assign w_in_xfer  = bus.in_valid && (r_state == ST_FILL);
  assign w_out_xfer = r_out_valid && bus.out_ready;
  // Result slot for the beat after the current one (results are ascending).
  assign w_next_sel = CW'(SIZE - 2) - r_rd_cnt;

  // Sort key = {magnitude, inverted slot}: keys are unique, and among equal
  // magnitudes the lowest slot sorts highest, so ties drain in arrival order.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      w_buf_key[i] = {r_buf[i], ~INDEX_WIDTH'(i)};
    end
  end

`ifdef SORT_PIPE_STAGE_EN
  logic [KW-1:0] r_net_key [SIZE];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SIZE; i++) r_net_key[i] <= '0;
    end else if (r_state == ST_LOAD) begin
      for (int unsigned i = 0; i < SIZE; i++) r_net_key[i] <= w_buf_key[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) w_net_in[i] = r_net_key[i];
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) w_net_in[i] = w_buf_key[i];
  end
`endif

  // Bitonic sorting network, ascending: w_net_out[SIZE-1] holds the maximum.
  always_comb begin
    w_swap = '0;
    for (int unsigned i = 0; i < SIZE; i++) w_net_out[i] = w_net_in[i];
    for (int unsigned k = 2; k <= SIZE; k = k << 1) begin
      for (int unsigned j = k >> 1; j > 0; j = j >> 1) begin
        for (int unsigned i = 0; i < SIZE; i++) begin
          if ((i ^ j) > i) begin
            if (((i & k) == 0) ? (w_net_out[i] > w_net_out[i ^ j])
                               : (w_net_out[i] < w_net_out[i ^ j])) begin
              w_swap             = w_net_out[i];
              w_net_out[i]       = w_net_out[i ^ j];
              w_net_out[i ^ j]   = w_swap;
            end
          end
        end
      end
    end
  end

  // Padding is not carried through the network; it is looked up by slot.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      w_sort_data[i] = w_net_out[i][KW-1 -: NETWORK_WIDTH];
      w_sort_idx[i]  = ~w_net_out[i][INDEX_WIDTH-1:0];
      w_sort_pad[i]  = r_pad[w_sort_idx[i][CW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_FILL;
      r_wr_ptr    <= '0;
      r_rd_cnt    <= '0;
      r_pad       <= '1;  // empty slots read as padding
      r_res_pad   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_pad   <= 1'b0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        r_buf[i]      <= '0;
        r_res_data[i] <= '0;
        r_res_idx[i]  <= '0;
      end
    end else begin
      r_overflow <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_in_xfer) begin
            r_buf[r_wr_ptr] <= bus.in_data;
            r_pad[r_wr_ptr] <= 1'b0;
            r_wr_ptr        <= r_wr_ptr + CW'(1);
            if (bus.in_last || (r_wr_ptr == CW'(SIZE - 1))) begin
`ifdef SORT_PIPE_STAGE_EN
              r_state <= ST_LOAD;
`else
              r_state <= ST_SORT;
`endif
              r_overflow <= !bus.in_last;
            end
          end
        end
        ST_LOAD: begin
          r_state <= ST_SORT;
        end
        ST_SORT: begin
          for (int unsigned i = 0; i < SIZE; i++) begin
            r_res_data[i] <= w_sort_data[i];
            r_res_idx[i]  <= w_sort_idx[i];
          end
          r_res_pad   <= w_sort_pad;
          r_out_valid <= 1'b1;
          r_out_data  <= w_sort_data[SIZE-1];
          r_out_index <= w_sort_idx[SIZE-1];
          r_out_pad   <= w_sort_pad[SIZE-1];
          r_out_last  <= (TOP_K == 1);
          r_rd_cnt    <= '0;
          r_state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_out_xfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_wr_ptr    <= '0;
              r_rd_cnt    <= '0;
              r_pad       <= '1;
              for (int unsigned i = 0; i < SIZE; i++) r_buf[i] <= '0;
              r_state     <= ST_FILL;
            end else begin
              r_rd_cnt    <= r_rd_cnt + CW'(1);
              r_out_data  <= r_res_data[w_next_sel];
              r_out_index <= r_res_idx[w_next_sel];
              r_out_pad   <= r_res_pad[w_next_sel];
              r_out_last  <= ((int'(r_rd_cnt) + 1) == (int'(TOP_K) - 1));
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_FILL);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_pad   = r_out_pad;
  assign bus.out_last  = r_out_last;
  assign overflow      = r_overflow;
endmodule
